// File: rtl/r7_redirect_unit_if.sv
// Redirect-unit bundle: EX-stage decode inputs, fetch handshake and status outputs.
// The optional R7_BRANCH_EN build adds eq_flag and branch_pc.
interface r7_redirect_unit_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned REG_BITS = 3
);
`ifdef R7_BRANCH_EN
    logic                eq_flag;
    logic [WIDTH-1:0]    branch_pc;
`endif
    logic                ex_valid;
    logic [3:0]          ex_opcode;
    logic [1:0]          ex_cond;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_jlr;
    logic [WIDTH-1:0]    alu_result;
    logic [WIDTH-1:0]    jalr_pc;
    logic [WIDTH-1:0]    incoming_pc;
    logic                fetch_ready;
    logic                redirect_valid;
    logic [WIDTH-1:0]    redirect_pc;
    logic                flush;
    logic                its_r7;
    logic [WIDTH-1:0]    redirect_count;

    modport master (
`ifdef R7_BRANCH_EN
        output eq_flag, branch_pc,
`endif
        output ex_valid, ex_opcode, ex_cond, ex_rd, ex_jlr,
        output alu_result, jalr_pc, incoming_pc, fetch_ready,
        input  redirect_valid, redirect_pc, flush, its_r7, redirect_count
    );

    modport slave (
`ifdef R7_BRANCH_EN
        input  eq_flag, branch_pc,
`endif
        input  ex_valid, ex_opcode, ex_cond, ex_rd, ex_jlr,
        input  alu_result, jalr_pc, incoming_pc, fetch_ready,
        output redirect_valid, redirect_pc, flush, its_r7, redirect_count
    );
endinterface

// File: rtl/r7_redirect_unit.sv
// PC redirect unit: turns EX-stage writes to the PC register and JLR jumps into a held
// fetch redirect followed by a fixed flush window. Macro R7_BRANCH_EN adds an eq-branch hit.
module r7_redirect_unit #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned REG_BITS     = 3,
    parameter int unsigned PC_REG       = 7,
    parameter int unsigned FLUSH_STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    r7_redirect_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StPending, StFlush} state_e;

    localparam logic [3:0] FlushInit = 4'(FLUSH_STAGES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             r7_q, r7_d;

    logic             alu_hit, jump_hit, branch_hit, any_hit;
    logic [WIDTH-1:0] target;

    always_comb begin
        alu_hit  = (bus.ex_rd == REG_BITS'(PC_REG)) &&
                   ((((bus.ex_opcode == 4'b0000) || (bus.ex_opcode == 4'b0010)) &&
                     (bus.ex_cond == 2'b00)) || (bus.ex_opcode == 4'b0001));
        jump_hit = bus.ex_jlr;
`ifdef R7_BRANCH_EN
        branch_hit = (bus.ex_opcode == 4'b1100) && bus.eq_flag;
`else
        branch_hit = 1'b0;
`endif
        any_hit = alu_hit || jump_hit || branch_hit;
        // Priority: ALU write to PC, then JLR, then branch.
        target = bus.incoming_pc;
        if (alu_hit) begin
            target = bus.alu_result;
        end else if (jump_hit) begin
            target = bus.jalr_pc;
        end else begin
`ifdef R7_BRANCH_EN
            if (branch_hit) target = bus.branch_pc;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        r7_d    = r7_q;
        unique case (state_q)
            StIdle: begin
                if (bus.ex_valid && any_hit) begin
                    pc_d    = target;
                    r7_d    = alu_hit;
                    state_d = StPending;
                end else begin
                    pc_d = bus.incoming_pc;
                    r7_d = 1'b0;
                end
            end
            StPending: begin
                // Target and its_r7 stay frozen; younger EX hits are wrong-path.
                if (bus.fetch_ready) begin
                    state_d = StFlush;
                    cnt_d   = FlushInit;
                    count_d = (count_q == '1) ? count_q : count_q + WIDTH'(1);
                end
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    r7_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            r7_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            r7_q    <= r7_d;
        end
    end

    assign bus.redirect_valid = (state_q == StPending);
    assign bus.flush          = (state_q != StIdle);
    assign bus.redirect_pc    = pc_q;
    assign bus.its_r7         = r7_q;
    assign bus.redirect_count = count_q;
endmodule

// File: tb/tb_r7_redirect_unit.sv
// Self-checking bench for r7_redirect_unit: vector table with scoreboard plus corner sequences.
module tb_r7_redirect_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_rst_n = 1'b0;
    always #5 clk = ~clk;

    r7_redirect_unit_if #(.WIDTH(16), .REG_BITS(3)) bus ();
    r7_redirect_unit_if #(.WIDTH(4), .REG_BITS(3)) sbus ();

    r7_redirect_unit #(.WIDTH(16), .REG_BITS(3), .PC_REG(7), .FLUSH_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    // Narrow instance so counter saturation is reachable in a short run.
    r7_redirect_unit #(.WIDTH(4), .REG_BITS(3), .PC_REG(7), .FLUSH_STAGES(2)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .bus(sbus)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [1:0]  cond;
        logic [2:0]  rd;
        logic        jlr;
        logic [15:0] alu;
        logic [15:0] jalr;
        logic [15:0] inc;
        logic        exp_rv;
        logic [15:0] exp_pc;
        logic        exp_r7;
    } vec_t;

    typedef struct {
        logic        rv;
        logic [15:0] pc;
        logic        r7;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_count = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [3:0] op, input logic [1:0] cond,
                            input logic [2:0] rd, input logic jlr, input logic [15:0] alu,
                            input logic [15:0] jalr, input logic [15:0] inc);
        bus.ex_valid    = v;
        bus.ex_opcode   = op;
        bus.ex_cond     = cond;
        bus.ex_rd       = rd;
        bus.ex_jlr      = jlr;
        bus.alu_result  = alu;
        bus.jalr_pc     = jalr;
        bus.incoming_pc = inc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.flush === 1'b1 && n < 16) begin
            step();
            n++;
        end
        if (n >= 16) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting for idle, flush=%0b", name, bus.flush);
        end
    endtask

    task automatic count_up();
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    endtask

    initial begin
        exp_t e;
`ifdef R7_BRANCH_EN
        bus.eq_flag   = 1'b0;
        bus.branch_pc = 16'h0;
`endif
        drive_ex(1'b0, 4'h0, 2'b00, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0);
        bus.fetch_ready = 1'b0;
        sbus.ex_valid    = 1'b1;
        sbus.ex_opcode   = 4'h0;
        sbus.ex_cond     = 2'b00;
        sbus.ex_rd       = 3'd7;
        sbus.ex_jlr      = 1'b0;
        sbus.alu_result  = 4'hA;
        sbus.jalr_pc     = 4'h3;
        sbus.incoming_pc = 4'h1;
        sbus.fetch_ready = 1'b1;
`ifdef R7_BRANCH_EN
        sbus.eq_flag   = 1'b0;
        sbus.branch_pc = 4'h0;
`endif

        vecs[0] = '{1'b1, 4'h0, 2'b00, 3'd7, 1'b0, 16'h1234, 16'h0000, 16'h0100, 1'b1, 16'h1234, 1'b1};
        vecs[1] = '{1'b1, 4'h1, 2'b00, 3'd7, 1'b1, 16'h00AA, 16'h0BB0, 16'h0102, 1'b1, 16'h00AA, 1'b1};
        vecs[2] = '{1'b1, 4'h1, 2'b00, 3'd3, 1'b1, 16'h00AA, 16'h0BB0, 16'h0104, 1'b1, 16'h0BB0, 1'b0};
        vecs[3] = '{1'b1, 4'h2, 2'b00, 3'd7, 1'b0, 16'h0777, 16'h0000, 16'h0106, 1'b1, 16'h0777, 1'b1};
        vecs[4] = '{1'b1, 4'h0, 2'b01, 3'd7, 1'b0, 16'h2222, 16'h0000, 16'h0108, 1'b0, 16'h0108, 1'b0};
        vecs[5] = '{1'b1, 4'h3, 2'b00, 3'd7, 1'b0, 16'h3333, 16'h0000, 16'h010A, 1'b0, 16'h010A, 1'b0};
        vecs[6] = '{1'b1, 4'hC, 2'b00, 3'd7, 1'b0, 16'h4444, 16'h0000, 16'h010C, 1'b0, 16'h010C, 1'b0};
        vecs[7] = '{1'b0, 4'h0, 2'b00, 3'd7, 1'b1, 16'h5555, 16'h6666, 16'h010E, 1'b0, 16'h010E, 1'b0};
        vecs[8] = '{1'b1, 4'h2, 2'b10, 3'd7, 1'b1, 16'h7777, 16'h4444, 16'h0110, 1'b1, 16'h4444, 1'b0};

        #12;
        check("reset_redirect_valid", 32'(bus.redirect_valid), 32'h0);
        check("reset_flush", 32'(bus.flush), 32'h0);
        check("reset_its_r7", 32'(bus.its_r7), 32'h0);
        check("reset_redirect_pc", 32'(bus.redirect_pc), 32'h0);
        check("reset_count", 32'(bus.redirect_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: one EX cycle per vector, response checked one cycle later.
        for (int i = 0; i < 9; i++) begin
            drive_ex(vecs[i].v, vecs[i].op, vecs[i].cond, vecs[i].rd, vecs[i].jlr,
                     vecs[i].alu, vecs[i].jalr, vecs[i].inc);
            sb.push_back('{vecs[i].exp_rv, vecs[i].exp_pc, vecs[i].exp_r7});
            step();
            bus.ex_valid = 1'b0;
            e = sb.pop_front();
            check($sformatf("vec%0d_redirect_valid", i), 32'(bus.redirect_valid), 32'(e.rv));
            check($sformatf("vec%0d_redirect_pc", i), 32'(bus.redirect_pc), 32'(e.pc));
            check($sformatf("vec%0d_its_r7", i), 32'(bus.its_r7), 32'(e.r7));
            check($sformatf("vec%0d_flush", i), 32'(bus.flush), 32'(e.rv));
            if (e.rv) begin
                bus.fetch_ready = 1'b1;
                step();
                bus.fetch_ready = 1'b0;
                count_up();
                wait_idle($sformatf("vec%0d_idle", i));
                check($sformatf("vec%0d_its_r7_cleared", i), 32'(bus.its_r7), 32'h0);
            end
            check($sformatf("vec%0d_count", i), 32'(bus.redirect_count), 32'(exp_count));
        end

        // Held redirect under backpressure, wrong-path hits in PENDING and FLUSH.
        drive_ex(1'b1, 4'h0, 2'b00, 3'd7, 1'b0, 16'h1234, 16'h0, 16'h0200);
        step();
        drive_ex(1'b1, 4'h0, 2'b00, 3'd7, 1'b0, 16'h5555, 16'h0, 16'h0202);
        check("hold_first_pc", 32'(bus.redirect_pc), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_valid", i), 32'(bus.redirect_valid), 32'h1);
            check($sformatf("hold%0d_pc", i), 32'(bus.redirect_pc), 32'h1234);
            check($sformatf("hold%0d_r7", i), 32'(bus.its_r7), 32'h1);
        end
        bus.fetch_ready = 1'b1;
        step();
        bus.fetch_ready = 1'b0;
        count_up();
        check("flush1_valid", 32'(bus.redirect_valid), 32'h0);
        check("flush1_flush", 32'(bus.flush), 32'h1);
        check("flush1_count", 32'(bus.redirect_count), 32'(exp_count));
        step();
        check("flush2_flush", 32'(bus.flush), 32'h1);
        check("flush2_pc", 32'(bus.redirect_pc), 32'h1234);
        bus.ex_valid = 1'b0;
        step();
        check("post_flush_flush", 32'(bus.flush), 32'h0);
        check("post_flush_r7", 32'(bus.its_r7), 32'h0);
        step();
        check("wrong_path_dropped", 32'(bus.redirect_valid), 32'h0);
        check("wrong_path_pc", 32'(bus.redirect_pc), 32'h0202);
        check("wrong_path_count", 32'(bus.redirect_count), 32'(exp_count));

`ifdef R7_BRANCH_EN
        drive_ex(1'b1, 4'hC, 2'b00, 3'd1, 1'b0, 16'h0, 16'h0, 16'h0300);
        bus.eq_flag   = 1'b1;
        bus.branch_pc = 16'h0040;
        step();
        bus.ex_valid = 1'b0;
        check("branch_valid", 32'(bus.redirect_valid), 32'h1);
        check("branch_pc", 32'(bus.redirect_pc), 32'h0040);
        check("branch_r7", 32'(bus.its_r7), 32'h0);
        bus.fetch_ready = 1'b1;
        step();
        bus.fetch_ready = 1'b0;
        count_up();
        wait_idle("branch_idle");
        bus.ex_valid = 1'b1;
        bus.eq_flag  = 1'b0;
        step();
        bus.ex_valid = 1'b0;
        check("branch_neq_valid", 32'(bus.redirect_valid), 32'h0);
        check("branch_count", 32'(bus.redirect_count), 32'(exp_count));
`endif

        // Asynchronous reset in the middle of the flush window.
        drive_ex(1'b1, 4'h1, 2'b00, 3'd7, 1'b0, 16'h0ABC, 16'h0, 16'h0400);
        bus.fetch_ready = 1'b1;
        step();
        bus.ex_valid = 1'b0;
        step();
        bus.fetch_ready = 1'b0;
        check("pre_reset_flush", 32'(bus.flush), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_flush", 32'(bus.flush), 32'h0);
        check("midreset_valid", 32'(bus.redirect_valid), 32'h0);
        check("midreset_count", 32'(bus.redirect_count), 32'h0);
        check("midreset_pc", 32'(bus.redirect_pc), 32'h0);
        check("midreset_r7", 32'(bus.its_r7), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'h0;
        step();
        check("after_reset_flush", 32'(bus.flush), 32'h0);

        // Back-to-back redirects on the 4-bit instance: count reaches 15 and sticks.
        @(negedge clk);
        s_rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("sat_count_30", 32'(sbus.redirect_count), 32'h8);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("sat_count_60", 32'(sbus.redirect_count), 32'hF);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("sat_count_100", 32'(sbus.redirect_count), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
